// File: rtl/first_one_iterator.sv
// first_one_iterator: walks every set bit of an accepted vector, LSB first,
// emitting one one-hot beat per set bit on a valid/ready output handshake.
// Optional feature macro: FIRST_ONE_ITERATOR_INDEX_EN adds the binary
// first_one_index output and its one-hot to binary encoder.
module first_one_iterator #(
    parameter int WIDTH = 8,
    localparam int INDEX_WIDTH = $clog2(WIDTH)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       data,
    input  logic                   data_valid,
    output logic                   data_ready,
    output logic [WIDTH-1:0]       first_one,
    output logic                   first_one_valid,
    input  logic                   first_one_ready,
    output logic                   first_one_last,
`ifdef FIRST_ONE_ITERATOR_INDEX_EN
    output logic [INDEX_WIDTH-1:0] first_one_index,
`endif
    output logic                   busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] pending_next;
    logic [WIDTH-1:0] lowest_bit;
    logic [WIDTH-1:0] remaining;

    // Isolate the lowest pending bit and the vector left once it is cleared
    always_comb begin
        lowest_bit = pending & (~pending + ONE);
        remaining  = pending & (pending - ONE);
    end

    // State and pending-vector registers; reset drops any vector mid-drain
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            pending <= '0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
        end
    end

    // Next-state logic and outputs, all derived from registered state
    always_comb begin
        state_next      = state;
        pending_next    = pending;
        data_ready      = 1'b0;
        busy            = 1'b0;
        first_one_valid = 1'b0;
        first_one       = '0;
        first_one_last  = 1'b0;
        case (state)
            IDLE: begin
                data_ready = 1'b1;
                if (data_valid && (data != '0)) begin
                    pending_next = data;
                    state_next   = DRAIN;
                end
            end
            DRAIN: begin
                busy            = 1'b1;
                first_one_valid = 1'b1;
                first_one       = lowest_bit;
                first_one_last  = (remaining == '0);
                if (first_one_ready) begin
                    if (remaining == '0) begin
                        pending_next = '0;
                        state_next   = IDLE;
                    end else begin
                        pending_next = remaining;
                    end
                end
            end
            default: begin
                pending_next = '0;
                state_next   = IDLE;
            end
        endcase
    end

`ifdef FIRST_ONE_ITERATOR_INDEX_EN
    // Encode the one-hot beat into its bit position (0 while idle)
    always_comb begin
        first_one_index = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (first_one[i]) begin
                first_one_index = INDEX_WIDTH'(i);
            end
        end
    end
`endif

endmodule

// File: tb/tb_first_one_iterator.sv
// tb_first_one_iterator: table-driven and hand-written sequences for
// first_one_iterator at WIDTH=8, plus an exhaustive sweep of all vectors.
// Index checks are compiled in when FIRST_ONE_ITERATOR_INDEX_EN is defined.
module tb_first_one_iterator;

   typedef struct {
      logic [7:0] data;
      bit         toggle;
      int         expBeats;
      logic [7:0] expFirst;
      logic [7:0] expFinal;
   } vec_t;

   logic       clock;
   logic       reset;
   logic [7:0] data;
   logic       data_valid;
   logic       data_ready;
   logic [7:0] first_one;
   logic       first_one_valid;
   logic       first_one_ready;
   logic       first_one_last;
`ifdef FIRST_ONE_ITERATOR_INDEX_EN
   logic [2:0] first_one_index;
`endif
   logic       busy;

   int checkCount = 0;
   int passCount  = 0;

   vec_t vectors[8];

   first_one_iterator #(.WIDTH(8)) dut (
      .clock           (clock),
      .reset           (reset),
      .data            (data),
      .data_valid      (data_valid),
      .data_ready      (data_ready),
      .first_one       (first_one),
      .first_one_valid (first_one_valid),
      .first_one_ready (first_one_ready),
      .first_one_last  (first_one_last),
`ifdef FIRST_ONE_ITERATOR_INDEX_EN
      .first_one_index (first_one_index),
`endif
      .busy            (busy)
   );

   // Free-running clock, rising edge active
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected)
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      else
         passCount++;
   endtask

   task automatic checkIdle(input string name);
      checkOutput({name, "_data_ready"}, 32'(data_ready), 32'd1);
      checkOutput({name, "_busy"}, 32'(busy), 32'd0);
      checkOutput({name, "_valid"}, 32'(first_one_valid), 32'd0);
      checkOutput({name, "_first_one"}, 32'(first_one), 32'd0);
      checkOutput({name, "_last"}, 32'(first_one_last), 32'd0);
`ifdef FIRST_ONE_ITERATOR_INDEX_EN
      checkOutput({name, "_index"}, 32'(first_one_index), 32'd0);
`endif
   endtask

   task automatic checkBeat(input string name, input logic [7:0] expBeat, input bit expLast, input int expPos);
      checkOutput({name, "_valid"}, 32'(first_one_valid), 32'd1);
      checkOutput({name, "_first_one"}, 32'(first_one), 32'(expBeat));
      checkOutput({name, "_last"}, 32'(first_one_last), 32'(expLast));
      checkOutput({name, "_busy"}, 32'(busy), 32'd1);
      checkOutput({name, "_data_ready"}, 32'(data_ready), 32'd0);
`ifdef FIRST_ONE_ITERATOR_INDEX_EN
      checkOutput({name, "_index"}, 32'(first_one_index), 32'(expPos));
`else
      if (expPos < 0) $display("[TB] unexpected negative position");
`endif
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge with it idle again
   task automatic applyStimulus(input logic [7:0] vec, input bit toggle,
                                output int beats, output logic [7:0] firstBeat, output logic [7:0] finalBeat);
      int pos[$];
      logic [7:0] expBeat;
      for (int b = 0; b < 8; b++)
         if (vec[b]) pos.push_back(b);
      beats     = 0;
      firstBeat = '0;
      finalBeat = '0;
      checkOutput("accept_data_ready", 32'(data_ready), 32'd1);
      data            = vec;
      data_valid      = 1'b1;
      first_one_ready = 1'b1;
      @(negedge clock);
      data_valid = 1'b0;
      data       = '0;
      for (int k = 0; k < pos.size(); k++) begin
         expBeat = 8'b1 << pos[k];
         checkBeat("beat", expBeat, (k == pos.size() - 1), pos[k]);
         if (toggle) begin
            first_one_ready = 1'b0;
            @(negedge clock);
            checkBeat("hold", expBeat, (k == pos.size() - 1), pos[k]);
            first_one_ready = 1'b1;
         end
         if (first_one_valid === 1'b1) begin
            if (beats == 0) firstBeat = first_one;
            finalBeat = first_one;
            beats++;
         end
         @(negedge clock);
      end
      checkIdle("drained");
   endtask

   initial begin
      int         beats;
      logic [7:0] firstBeat;
      logic [7:0] finalBeat;
      logic [7:0] vv;

      vectors[0] = '{8'b1010_0100, 1'b0, 3, 8'h04, 8'h80};
      vectors[1] = '{8'b0000_0000, 1'b0, 0, 8'h00, 8'h00};
      vectors[2] = '{8'hFF,        1'b1, 8, 8'h01, 8'h80};
      vectors[3] = '{8'b1000_0000, 1'b0, 1, 8'h80, 8'h80};
      vectors[4] = '{8'h01,        1'b0, 1, 8'h01, 8'h01};
      vectors[5] = '{8'h03,        1'b0, 2, 8'h01, 8'h02};
      vectors[6] = '{8'h81,        1'b1, 2, 8'h01, 8'h80};
      vectors[7] = '{8'h7E,        1'b1, 6, 8'h02, 8'h40};

      reset           = 1'b1;
      data            = '0;
      data_valid      = 1'b0;
      first_one_ready = 1'b0;
      repeat (2) @(negedge clock);
      checkIdle("reset_hold");
      reset = 1'b0;
      @(negedge clock);
      checkIdle("reset_after");

      $display("[TB] directed vector table");
      for (int i = 0; i < 8; i++) begin
         applyStimulus(vectors[i].data, vectors[i].toggle, beats, firstBeat, finalBeat);
         checkOutput("tbl_beats", 32'(beats), 32'(vectors[i].expBeats));
         checkOutput("tbl_first", 32'(firstBeat), 32'(vectors[i].expFirst));
         checkOutput("tbl_final", 32'(finalBeat), 32'(vectors[i].expFinal));
      end

      $display("[TB] reset during drain");
      data            = 8'hF0;
      data_valid      = 1'b1;
      first_one_ready = 1'b1;
      @(negedge clock);
      data_valid = 1'b0;
      checkBeat("rst_beat0", 8'h10, 1'b0, 4);
      @(negedge clock);
      checkBeat("rst_beat1", 8'h20, 1'b0, 5);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      checkIdle("rst_mid");
      repeat (3) begin
         @(negedge clock);
         checkIdle("rst_after");
      end

      $display("[TB] back-to-back with data_valid held");
      data            = 8'h03;
      data_valid      = 1'b1;
      first_one_ready = 1'b1;
      @(negedge clock);
      data = 8'h81;
      checkBeat("b2b_a0", 8'h01, 1'b0, 0);
      @(negedge clock);
      checkBeat("b2b_a1", 8'h02, 1'b1, 1);
      @(negedge clock);
      checkIdle("b2b_gap");
      @(negedge clock);
      data_valid = 1'b0;
      data       = '0;
      checkBeat("b2b_b0", 8'h01, 1'b0, 0);
      @(negedge clock);
      checkBeat("b2b_b1", 8'h80, 1'b1, 7);
      @(negedge clock);
      checkIdle("b2b_end");

      $display("[TB] exhaustive sweep");
      for (int v = 0; v < 256; v++) begin
         vv = v[7:0];
         applyStimulus(vv, vv[0], beats, firstBeat, finalBeat);
         checkOutput("sweep_popcount", 32'(beats), 32'($countones(vv)));
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
